// File: rtl/framebuffer_scan_reader_pkg.sv
// framebuffer_scan_reader_pkg: shared pixel, SRAM port and reader state types
package framebuffer_scan_reader_pkg;
   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } VgaColor_t;
   typedef struct packed {
      VgaColor_t pixelOdd;
      VgaColor_t pixelEven;
   } Pixel_t;
   typedef logic [19:0] SramAddress_t;
   typedef struct packed {
      SramAddress_t address;
      Pixel_t       dout;
      logic         den;
      logic         oe_n;
      logic         we_n;
   } SramRequest_t;
   typedef struct packed {
      logic   done;
      Pixel_t din;
   } SramResult_t;
   typedef enum logic [2:0] {IDLE, FETCH, READ, DRAIN, DONE} FrameReaderState_t;
   function automatic int unsigned word_count_width(int unsigned n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/framebuffer_scan_reader_pixel_word_fifo.sv
// pixel_word_fifo: show-ahead synchronous FIFO of packed pixel pairs with flush
module pixel_word_fifo
   import framebuffer_scan_reader_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push_i,
   input  Pixel_t data_i,
   input  logic   pop_i,
   input  logic   flush_i,
   output Pixel_t head_o,
   output logic   full_o,
   output logic   empty_o
);
   localparam int AW = $clog2(DEPTH);
   Pixel_t mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0] count_q;
   logic do_push, do_pop;
   assign full_o = count_q == (AW+1)'(DEPTH);
   assign empty_o = count_q == '0;
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop = pop_i && !empty_o;
   assign head_o = mem_q[rd_q];
   // pointers and occupancy; flush discards everything buffered
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         wr_q <= '0;
         rd_q <= '0;
         count_q <= '0;
      end else begin
         wr_q <= wr_q + AW'(do_push);
         rd_q <= rd_q + AW'(do_pop);
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   // word storage, unreset: contents only matter behind valid pointers
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/framebuffer_scan_reader.sv
// framebuffer_scan_reader: fetches framebuffer words from SRAM and pops them as single pixels
module framebuffer_scan_reader
   import framebuffer_scan_reader_pkg::*;
#(
   parameter int H_PIXELS   = 640,
   parameter int V_LINES    = 480,
   parameter int FIFO_DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         frameStart,
   input  SramAddress_t baseAddress,
   output SramRequest_t ramRequest,
   input  SramResult_t  ramResult,
   input  logic         pixelReq,
   output VgaColor_t    pixel,
   output logic         underflow,
   output logic         frameDone
);
   localparam int N = H_PIXELS * V_LINES / 2;
   localparam int CW = word_count_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   FrameReaderState_t state_q;
   SramAddress_t base_q, addr_q;
   logic [CW-1:0] count_q;
   logic den_q, done_q, half_q, underflow_q;
   Pixel_t head;
   logic full, empty, push, pop;
   assign push = state_q == READ && ramResult.done && !frameStart;
   assign pop = pixelReq && !empty && half_q && !frameStart;
   assign pixel = empty ? '0 : (half_q ? head.pixelEven : head.pixelOdd);
   assign underflow = underflow_q;
   assign frameDone = done_q;
   assign ramRequest = '{address: addr_q, dout: '0, den: den_q, oe_n: !den_q, we_n: 1'b1};
   pixel_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push),
      .data_i (ramResult.din),
      .pop_i  (pop),
      .flush_i(frameStart),
      .head_o (head),
      .full_o (full),
      .empty_o(empty)
   );
   // fetch sequencer: one read in flight, a restart mid-read drains it without keeping the data
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         base_q <= '0;
         addr_q <= '0;
         count_q <= '0;
         den_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         if (frameStart) base_q <= baseAddress;
         if (frameStart) done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: if (frameStart) begin
               state_q <= FETCH;
               count_q <= '0;
            end
            FETCH: if (frameStart) count_q <= '0;
            else if (!full) begin
               state_q <= READ;
               den_q <= 1'b1;
               addr_q <= base_q + SramAddress_t'(count_q);
            end
            READ: if (ramResult.done) begin
               den_q <= 1'b0;
               if (frameStart) begin
                  state_q <= FETCH;
                  count_q <= '0;
               end else begin
                  count_q <= count_q + 1'b1;
                  state_q <= count_q == LAST ? DONE : FETCH;
                  done_q <= count_q == LAST;
               end
            end else if (frameStart) state_q <= DRAIN;
            DRAIN: if (ramResult.done) begin
               den_q <= 1'b0;
               state_q <= FETCH;
               count_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   // pop side: half-select walks odd then even pixel of the head word; underflow is sticky per frame
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         half_q <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         half_q <= !frameStart && (half_q ^ (pixelReq && !empty));
         underflow_q <= !frameStart && (underflow_q || (pixelReq && empty));
      end
endmodule

// File: tb/tb_framebuffer_scan_reader.sv
// tb_framebuffer_scan_reader: directed bench with a pixel-queue reference model and SRAM responder
module tb_framebuffer_scan_reader;
   import framebuffer_scan_reader_pkg::*;
   localparam int H = 8, V = 6, N = H * V / 2, DEPTH = 16;
   logic clk = 1'b0, rst = 1'b1, frameStart = 1'b0, pixelReq = 1'b0;
   SramAddress_t baseAddress = '0;
   SramRequest_t ramRequest;
   SramResult_t ramResult = '0;
   VgaColor_t pixel;
   logic underflow, frameDone;
   int n_chk = 0, n_fail = 0, reads = 0, dcnt = 0, k = 0, words_pre = 0;
   VgaColor_t q[$];
   SramAddress_t base_m = '0, addr_s = '0;
   logic stale = 1'b0, und_m = 1'b0, fd_m = 1'b0, den_s = 1'b0;
   Pixel_t w;

   always #5 clk = ~clk;

   framebuffer_scan_reader #(.H_PIXELS(H), .V_LINES(V), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .frameStart (frameStart),
      .baseAddress(baseAddress),
      .ramRequest (ramRequest),
      .ramResult  (ramResult),
      .pixelReq   (pixelReq),
      .pixel      (pixel),
      .underflow  (underflow),
      .frameDone  (frameDone)
   );

   function automatic Pixel_t mem_word(SramAddress_t a);
      Pixel_t p;
      p.pixelOdd = a[7:0] ^ 8'hA5 ^ {a[9:8], 6'b0};
      p.pixelEven = a[7:0] ^ 8'h3C;
      return p;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_den(logic lvl, int max);
      for (int i = 0; i < max && ramRequest.den !== lvl; i++) tick();
      chk("wait_den", 32'(ramRequest.den), 32'(lvl));
   endtask

   task automatic wait_q(int n, int max);
      for (int i = 0; i < max && q.size() < n; i++) tick();
      chk("wait_pixels", 32'(q.size() >= n), 1);
   endtask

   // SRAM responder: completes each read 3 cycles after den rises
   always @(negedge clk) begin
      ramResult.done = 1'b0;
      if (ramRequest.den) begin
         dcnt++;
         if (dcnt == 3) begin
            ramResult.done = 1'b1;
            ramResult.din = mem_word(ramRequest.address);
            dcnt = 0;
            reads++;
         end
      end else dcnt = 0;
   end

   // reference model: frame-ordered pixel queue, updated per edge and compared every cycle
   always @(posedge clk) begin
      #1;
      if (rst) begin
         q.delete();
         base_m = '0;
         k = 0;
         stale = 1'b0;
         und_m = 1'b0;
         fd_m = 1'b0;
      end else begin
         words_pre = (q.size() + 1) / 2;
         if (!frameStart && pixelReq) begin
            if (q.size() > 0) void'(q.pop_front());
            else und_m = 1'b1;
         end
         if (ramResult.done && den_s) begin
            if (!stale && !frameStart) begin
               chk("read_addr", 32'(addr_s), 32'(base_m + SramAddress_t'(k)));
               w = mem_word(base_m + SramAddress_t'(k));
               q.push_back(w.pixelOdd);
               q.push_back(w.pixelEven);
               k++;
               if (k == N) fd_m = 1'b1;
            end
            stale = 1'b0;
         end else if (frameStart && den_s) stale = 1'b1;
         if (frameStart) begin
            base_m = baseAddress;
            k = 0;
            q.delete();
            und_m = 1'b0;
            fd_m = 1'b0;
         end
         if (!den_s && ramRequest.den) chk("den_room", 32'(words_pre < DEPTH), 1);
         if (den_s && ramRequest.den) chk("addr_stable", 32'(ramRequest.address), 32'(addr_s));
      end
      chk("pixel", 32'(pixel), 32'(q.size() > 0 ? q[0] : VgaColor_t'(0)));
      chk("underflow", 32'(underflow), 32'(und_m));
      chk("frameDone", 32'(frameDone), 32'(fd_m));
      chk("oe_n", 32'(ramRequest.oe_n), 32'(!ramRequest.den));
      chk("we_n", 32'(ramRequest.we_n), 1);
      chk("dout", 32'(ramRequest.dout), 0);
      den_s = ramRequest.den;
      addr_s = ramRequest.address;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tick(2);
      chk("rst_den", 32'(ramRequest.den), 0);
      chk("rst_oe_n", 32'(ramRequest.oe_n), 1);
      chk("rst_addr", 32'(ramRequest.address), 0);
      chk("rst_pixel", 32'(pixel), 0);
      chk("rst_underflow", 32'(underflow), 0);
      chk("rst_frameDone", 32'(frameDone), 0);
      rst = 1'b0;
      tick();
      frameStart = 1'b1;
      baseAddress = 20'h100;
      tick();
      frameStart = 1'b0;
      baseAddress = 20'hFFF;
      chk("fs_den_1", 32'(ramRequest.den), 0);
      tick();
      chk("fs_den_2", 32'(ramRequest.den), 1);
      chk("first_addr", 32'(ramRequest.address), 32'h100);
      tick(150);
      chk("reads_full", reads, 16);
      chk("stall_den", 32'(ramRequest.den), 0);
      chk("pix_a", 32'(pixel), 32'hE5);
      pixelReq = 1'b1;
      tick();
      chk("pix_b", 32'(pixel), 32'h3C);
      tick();
      pixelReq = 1'b0;
      chk("pix_c", 32'(pixel), 32'hE4);
      tick(20);
      chk("reads_one_more", reads, 17);
      for (int i = 0; i < 1000 && !(frameDone && q.size() == 0); i++) begin
         pixelReq = q.size() > 0;
         tick();
      end
      pixelReq = 1'b0;
      chk("reads_frame", reads, N);
      chk("frame_done", 32'(frameDone), 1);
      chk("no_underflow", 32'(underflow), 0);
      tick(10);
      chk("done_den", 32'(ramRequest.den), 0);
      chk("done_reads", reads, N);
      pixelReq = 1'b1;
      tick(3);
      chk("und_set", 32'(underflow), 1);
      chk("und_pixel", 32'(pixel), 0);
      pixelReq = 1'b0;
      tick(3);
      chk("und_sticky", 32'(underflow), 1);
      frameStart = 1'b1;
      baseAddress = 20'h300;
      tick();
      frameStart = 1'b0;
      chk("und_clear", 32'(underflow), 0);
      chk("fd_clear", 32'(frameDone), 0);
      wait_den(1'b1, 10);
      frameStart = 1'b1;
      baseAddress = 20'h200;
      tick();
      frameStart = 1'b0;
      chk("drain_den", 32'(ramRequest.den), 1);
      chk("drain_addr", 32'(ramRequest.address), 32'h300);
      chk("drain_pixel", 32'(pixel), 0);
      wait_den(1'b0, 10);
      wait_den(1'b1, 10);
      chk("restart_addr", 32'(ramRequest.address), 32'h200);
      chk("restart_pixel", 32'(pixel), 0);
      wait_q(4, 30);
      chk("restart_first", 32'(pixel), 32'h25);
      pixelReq = 1'b1;
      tick();
      pixelReq = 1'b0;
      chk("restart_second", 32'(pixel), 32'h3C);
      frameStart = 1'b1;
      pixelReq = 1'b1;
      baseAddress = 20'h100;
      tick();
      frameStart = 1'b0;
      pixelReq = 1'b0;
      chk("collide_pixel", 32'(pixel), 0);
      chk("collide_und", 32'(underflow), 0);
      wait_q(1, 20);
      chk("collide_first", 32'(pixel), 32'hE5);
      wait_den(1'b1, 20);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_den", 32'(ramRequest.den), 0);
      chk("rst_mid_oe_n", 32'(ramRequest.oe_n), 1);
      chk("rst_mid_pixel", 32'(pixel), 0);
      chk("rst_mid_und", 32'(underflow), 0);
      tick();
      rst = 1'b0;
      tick(3);
      chk("post_rst_den", 32'(ramRequest.den), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
